// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// The grant-choice helper is reused by anything that needs the round-robin rule.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_CNT_W   = 5;

  // On a tie the requester that did not win last time gets the port.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    return (req0 & req1) ? ~last : req1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter, grouped into one bundle.
// Handshake: a grant holds mem_valid high until the cycle mem_ready is sampled high or the wait bound expires.
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0;
  logic             we0;
  logic [WIDTH-1:0] addr0;
  logic [WIDTH-1:0] wdata0;
  logic             ack0;
  logic             err0;
  logic             req1;
  logic             we1;
  logic [WIDTH-1:0] addr1;
  logic [WIDTH-1:0] wdata1;
  logic             ack1;
  logic             err1;
  logic [WIDTH-1:0] rdata;
  logic             sel;
  logic             mem_valid;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ready;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_ready, mem_rdata,
    output ack0, err0, ack1, err1, rdata, sel, mem_valid, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_ready, mem_rdata,
    input  ack0, err0, ack1, err1, rdata, sel, mem_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mux2to1by32.sv
// 32-bit 2:1 steering mux; i_sel=0 passes i_d0.
module mux2to1by32 (
  input  logic [31:0] i_d0,
  input  logic [31:0] i_d1,
  input  logic        i_sel,
  output logic [31:0] o_y
);
  assign o_y = i_sel ? i_d1 : i_d0;
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters,
// with a bounded wait for mem_ready and a one-cycle ack/err response pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output state_t              o_state
);

  state_t             r_state;
  logic               r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sel;
  logic               r_mem_valid;
  logic               r_ack0;
  logic               r_ack1;
  logic               r_err0;
  logic               r_err1;
  logic [WIDTH-1:0]   r_rdata;

  logic               w_winner;
  logic               w_busy_idx;
  logic               w_timeout;
  logic [WIDTH-1:0]   w_mem_addr;
  logic [WIDTH-1:0]   w_mem_wdata;

  assign w_winner   = rr_pick(bus.req0, bus.req1, r_last);
  assign w_busy_idx = (r_state == BUSY1);
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_sel       <= 1'b0;
      r_mem_valid <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            r_state     <= w_winner ? BUSY1 : BUSY0;
            r_sel       <= w_winner;
            r_cnt       <= '0;
            r_mem_valid <= 1'b1;
          end
        end
        BUSY0, BUSY1: begin
          // Completion takes priority over a timeout landing on the same cycle.
          if (bus.mem_ready) begin
            r_rdata     <= bus.mem_rdata;
            r_ack0      <= ~w_busy_idx;
            r_ack1      <= w_busy_idx;
            r_last      <= w_busy_idx;
            r_state     <= IDLE;
            r_mem_valid <= 1'b0;
          end else if (w_timeout) begin
            r_err0      <= ~w_busy_idx;
            r_err1      <= w_busy_idx;
            r_last      <= w_busy_idx;
            r_state     <= IDLE;
            r_mem_valid <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_mem_valid <= 1'b0;
        end
      endcase
    end
  end

  mux2to1by32 u_addr_mux (
    .i_d0  (bus.addr0),
    .i_d1  (bus.addr1),
    .i_sel (r_sel),
    .o_y   (w_mem_addr)
  );

  mux2to1by32 u_wdata_mux (
    .i_d0  (bus.wdata0),
    .i_d1  (bus.wdata1),
    .i_sel (r_sel),
    .o_y   (w_mem_wdata)
  );

  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.mem_we    = r_sel ? bus.we1 : bus.we0;
  assign bus.mem_valid = r_mem_valid;
  assign bus.sel       = r_sel;
  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;
  assign bus.err0      = r_err0;
  assign bus.err1      = r_err1;
  assign bus.rdata     = r_rdata;
  assign o_state       = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts grant order,
// memory timing and responses; a memory responder and a response monitor check the DUT.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int W  = 32;
  localparam int TO = 16;

  typedef struct {
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    int           delay;
  } txn_t;

  typedef struct {
    logic         idx;
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    int           delay;
  } plan_t;

  // ---------------- clock / reset / DUT ----------------
  logic   clk = 1'b0;
  logic   reset;
  state_t dbg_state;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WIDTH(W)) bus ();

  mem_port_arbiter #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [W+1:0] exp_q[$];   // {is_err, idx, rdata}
  plan_t        plan_q[$];  // memory behaviour per grant, in predicted grant order

  logic         m_last  = 1'b1;
  logic [W-1:0] m_rdata = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      6:       return TO - 1;
      7:       return TO;
      8:       return TO - 2;
      9:       return 40;
      default: return $urandom_range(0, 4);
    endcase
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = $urandom;
    t.wdata = $urandom;
    t.rdata = $urandom;
    t.delay = pick_delay();
    return t;
  endfunction

  // ---------------- driver ----------------
  // Each selected requester issues `reps` back-to-back transactions, holding req across them.
  task automatic issue(input logic do0, input logic do1, input txn_t t0, input txn_t t1, input int reps);
    int    rem0, rem1, total, got, cyc;
    logic  cur, ok, any;
    bit    exp_busy;
    txn_t  t;
    plan_t p;
    rem0  = do0 ? reps : 0;
    rem1  = do1 ? reps : 0;
    total = rem0 + rem1;
    cur   = (do0 && do1) ? ~m_last : do1;
    for (int k = 0; k < total; k++) begin
      t       = cur ? t1 : t0;
      p.idx   = cur;
      p.we    = t.we;
      p.addr  = t.addr;
      p.wdata = t.wdata;
      p.rdata = t.rdata;
      p.delay = t.delay;
      plan_q.push_back(p);
      ok = (t.delay <= TO - 1);
      if (ok) m_rdata = t.rdata;
      exp_q.push_back({~ok, cur, m_rdata});
      m_last = cur;
      if (do0 && do1) cur = ~cur;
    end
    if (do0) begin
      bus.we0 = t0.we; bus.addr0 = t0.addr; bus.wdata0 = t0.wdata; bus.req0 = 1'b1;
    end
    if (do1) begin
      bus.we1 = t1.we; bus.addr1 = t1.addr; bus.wdata1 = t1.wdata; bus.req1 = 1'b1;
    end
    got = 0; cyc = 0; exp_busy = 0;
    while (got < total && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (exp_busy) begin
        check("regrant_after_dead_cycle", W'(bus.mem_valid), W'(1));
        exp_busy = 0;
      end
      any = bus.ack0 | bus.err0 | bus.ack1 | bus.err1;
      if (bus.ack0 || bus.err0) begin
        got++; rem0--;
        if (rem0 <= 0) bus.req0 = 1'b0;
      end
      if (bus.ack1 || bus.err1) begin
        got++; rem1--;
        if (rem1 <= 0) bus.req1 = 1'b0;
      end
      if (any && got < total) exp_busy = 1;
    end
    if (got < total) begin
      n_cmp++; n_fail++;
      $display("FAIL round_timeout: got %0d responses expected %0d", got, total);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      exp_q.delete();
      plan_q.delete();
    end
  endtask

  // Grant requester 1, then hit reset on its 2nd BUSY cycle.
  task automatic reset_mid_txn();
    plan_t p;
    int    cyc;
    p.idx = 1'b1; p.we = 1'b0; p.addr = $urandom; p.wdata = $urandom;
    p.rdata = $urandom; p.delay = 40;
    plan_q.push_back(p);
    bus.we1 = p.we; bus.addr1 = p.addr; bus.wdata1 = p.wdata; bus.req1 = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!bus.mem_valid && cyc < 10);
    check("rst_grant_seen", W'(bus.mem_valid), W'(1));
    @(posedge clk); #1;
    check("rst_busy1_state", W'(dbg_state), W'(BUSY1));
    reset = 1'b1;
    bus.req1 = 1'b0;
    @(posedge clk); #1;
    check("rst_state_idle", W'(dbg_state), W'(IDLE));
    check("rst_mem_valid", W'(bus.mem_valid), W'(0));
    check("rst_ack1", W'(bus.ack1), W'(0));
    check("rst_err1", W'(bus.err1), W'(0));
    check("rst_sel", W'(bus.sel), W'(0));
    check("rst_rdata", bus.rdata, W'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    m_last  = 1'b1;
    m_rdata = '0;
    plan_q.delete();
  endtask

  // ---------------- memory responder ----------------
  plan_t cur_plan;
  bit    mem_active = 0;
  int    busy_len   = 0;

  always @(negedge clk) begin
    if (reset) begin
      mem_active    = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
    end else if (bus.mem_valid) begin
      if (!mem_active) begin
        mem_active = 1;
        busy_len   = 0;
        if (plan_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unplanned_grant: sel %0d at %0t", bus.sel, $time);
          cur_plan.idx = bus.sel; cur_plan.we = bus.mem_we; cur_plan.addr = bus.mem_addr;
          cur_plan.wdata = bus.mem_wdata; cur_plan.rdata = '0; cur_plan.delay = 0;
        end else begin
          cur_plan = plan_q.pop_front();
        end
        check("grant_sel", W'(bus.sel), W'(cur_plan.idx));
        check("mem_addr", bus.mem_addr, cur_plan.addr);
        check("mem_we", W'(bus.mem_we), W'(cur_plan.we));
        check("mem_wdata", bus.mem_wdata, cur_plan.wdata);
      end
      busy_len++;
      bus.mem_ready = ((busy_len - 1) == cur_plan.delay);
      bus.mem_rdata = bus.mem_ready ? cur_plan.rdata : $urandom;
    end else begin
      if (mem_active)
        check("busy_cycles", W'(busy_len),
              W'((cur_plan.delay <= TO - 1) ? cur_plan.delay + 1 : TO));
      mem_active    = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
    end
  end

  // ---------------- response monitor ----------------
  logic [W+1:0] e;

  always @(negedge clk) begin
    if (!reset && (bus.ack0 || bus.ack1 || bus.err0 || bus.err1)) begin
      check("one_response_pulse",
            W'(int'(bus.ack0) + int'(bus.ack1) + int'(bus.err0) + int'(bus.err1)), W'(1));
      check("idle_during_response", W'(bus.mem_valid), W'(0));
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_response: ack0 %0d ack1 %0d err0 %0d err1 %0d expected none",
                 bus.ack0, bus.ack1, bus.err0, bus.err1);
      end else begin
        e = exp_q.pop_front();
        check("resp_is_err", W'(bus.err0 | bus.err1), W'(e[W+1]));
        check("resp_idx", W'(bus.ack1 | bus.err1), W'(e[W]));
        check("rdata", bus.rdata, e[W-1:0]);
        check("sel_holds", W'(bus.sel), W'(e[W]));
      end
    end
  end

  // ---------------- stimulus ----------------
  txn_t ta, tb;

  initial begin
    reset = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset: everything at reset values for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_mem_valid", W'(bus.mem_valid), W'(0));
      check("idle_sel", W'(bus.sel), W'(0));
      check("idle_resp", W'({bus.ack0, bus.ack1, bus.err0, bus.err1}), W'(0));
      check("idle_rdata", bus.rdata, W'(0));
      check("idle_state", W'(dbg_state), W'(IDLE));
    end
    @(posedge clk); #1;

    // Requester 0 read, ready on the 3rd BUSY cycle.
    ta = '{we: 1'b0, addr: 32'h0000_0040, wdata: 32'h0, rdata: 32'hDEAD_BEEF, delay: 2};
    tb = rand_txn();
    issue(1'b1, 1'b0, ta, tb, 1);

    // Requester 1 write.
    tb = '{we: 1'b1, addr: 32'h0000_1000, wdata: 32'h9400_C187, rdata: 32'h1234_5678, delay: 1};
    issue(1'b0, 1'b1, ta, tb, 1);

    // Both held, memory ready every cycle: grants 0,1,0,1.
    ta = rand_txn(); ta.delay = 0;
    tb = rand_txn(); tb.delay = 0;
    issue(1'b1, 1'b1, ta, tb, 2);

    // Requester 0 times out while requester 1 waits.
    ta = rand_txn(); ta.delay = 40;
    tb = rand_txn(); tb.delay = 1;
    issue(1'b1, 1'b1, ta, tb, 1);

    reset_mid_txn();
    ta = rand_txn(); tb = rand_txn();
    issue(1'b1, 1'b1, ta, tb, 1);

    for (int r = 0; r < 60; r++) begin
      int sel_mask;
      sel_mask = $urandom_range(1, 3);
      ta = rand_txn();
      tb = rand_txn();
      issue(sel_mask[0], sel_mask[1], ta, tb, (sel_mask == 3) ? $urandom_range(1, 2) : 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", W'(exp_q.size()), W'(0));
    check("plan_q_drained", W'(plan_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
